// File: rtl/ula_pkg.sv
// Shared codes for the ULA issue path: ULA control codes, ALUOp/funct encodings, FSM states.
package ula_pkg;

  localparam int unsigned CTRL_W   = 3;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned STATE_W  = 2;
  localparam int unsigned PERF_W   = 32;

  localparam logic [CTRL_W-1:0] ULA_AND = 3'b000;
  localparam logic [CTRL_W-1:0] ULA_OR  = 3'b001;
  localparam logic [CTRL_W-1:0] ULA_ADD = 3'b010;
  localparam logic [CTRL_W-1:0] ULA_SUB = 3'b110;
  localparam logic [CTRL_W-1:0] ULA_SLT = 3'b111;
  localparam logic [CTRL_W-1:0] ULA_NOR = 3'b100;
  localparam logic [CTRL_W-1:0] ULA_ILL = 3'b011;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ILL   = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

  typedef enum logic [STATE_W-1:0] {IDLE, EXEC, DONE} ula_issue_state_t;

  localparam logic [STATE_W-1:0] ST_IDLE = STATE_W'(IDLE);
  localparam logic [STATE_W-1:0] ST_EXEC = STATE_W'(EXEC);
  localparam logic [STATE_W-1:0] ST_DONE = STATE_W'(DONE);

endpackage

// File: rtl/ula_decode.sv
// Combinational ALUOp/funct -> ULA control decoder; flags anything it cannot map as an error.
module ula_decode
  import ula_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_alu_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [CTRL_W-1:0]  o_control_c,
  output logic               o_err_c
);

  always_comb begin
    o_control_c = ULA_ILL;
    o_err_c     = 1'b1;
    case (i_alu_op)
      ALUOP_ADD: begin
        o_control_c = ULA_ADD;
        o_err_c     = 1'b0;
      end
      ALUOP_SUB: begin
        o_control_c = ULA_SUB;
        o_err_c     = 1'b0;
      end
      ALUOP_RTYPE: begin
        o_err_c = 1'b0;
        case (i_funct)
          FUNCT_ADD: o_control_c = ULA_ADD;
          FUNCT_SUB: o_control_c = ULA_SUB;
          FUNCT_AND: o_control_c = ULA_AND;
          FUNCT_OR:  o_control_c = ULA_OR;
          FUNCT_SLT: o_control_c = ULA_SLT;
          FUNCT_NOR: o_control_c = ULA_NOR;
          default: begin
            o_control_c = ULA_ILL;
            o_err_c     = 1'b1;
          end
        endcase
      end
      ALUOP_ILL: begin
        o_control_c = ULA_ILL;
        o_err_c     = 1'b1;
      end
      default: begin
        o_control_c = ULA_ILL;
        o_err_c     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ula_issue_ctrl.sv
// ULA initiator: accepts an op, drives registered operands/control to the ULA, returns the captured result.
// Optional build macro ULA_ISSUE_PERF_EN adds perf_ops/perf_err handshake counters.
module ula_issue_ctrl
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [CTRL_W-1:0]  ula_control,
  output logic [WIDTH-1:0]   ula_a,
  output logic [WIDTH-1:0]   ula_b,
  input  logic [WIDTH-1:0]   ula_result,
  input  logic               ula_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_err
`ifdef ULA_ISSUE_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_ops,
  output logic [PERF_W-1:0]  perf_err
`endif
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_out_hs;

  logic [CTRL_W-1:0]  w_dec_ctrl;
  logic               w_dec_err;

  logic [CTRL_W-1:0]  r_ctrl;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_err;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_oerr;
  logic               r_valid;

  ula_decode u_decode (
    .i_alu_op    (alu_op),
    .i_funct     (funct),
    .o_control_c (w_dec_ctrl),
    .o_err_c     (w_dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake; in_ready depends combinationally only on out_ready and state.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_hs    = r_valid & out_ready;
    case (r_state)
      ST_IDLE: w_in_ready = rst_n;
      ST_DONE: w_in_ready = rst_n & out_ready;
      default: w_in_ready = 1'b0;
    endcase
    w_accept = in_valid & w_in_ready;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand/control registers change only on accept, so the ULA sees stable inputs through EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= ULA_AND;
      r_a    <= '0;
      r_b    <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_ctrl <= w_dec_ctrl;
      r_a    <= op_a;
      r_b    <= op_b;
      r_err  <= w_dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_oerr   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_result <= ula_result;
      r_zero   <= ula_zero & ~r_err;
      r_oerr   <= r_err;
      r_valid  <= 1'b1;
    end else if (w_out_hs) begin
      r_valid  <= 1'b0;
    end
  end

`ifdef ULA_ISSUE_PERF_EN
  logic [PERF_W-1:0] r_perf_ops;
  logic [PERF_W-1:0] r_perf_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_ops <= '0;
      r_perf_err <= '0;
    end else if (w_out_hs) begin
      r_perf_ops <= r_perf_ops + PERF_W'(1);
      if (r_oerr) r_perf_err <= r_perf_err + PERF_W'(1);
    end
  end

  assign perf_ops = r_perf_ops;
  assign perf_err = r_perf_err;
`endif

  assign in_ready    = w_in_ready;
  assign ula_control = r_ctrl;
  assign ula_a       = r_a;
  assign ula_b       = r_b;
  assign out_valid   = r_valid;
  assign out_result  = r_result;
  assign out_zero    = r_zero;
  assign out_err     = r_oerr;

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Directed bench for ula_issue_ctrl with a behavioural ULA responder; perf checks under ULA_ISSUE_PERF_EN.
module tb_ula_issue_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   ula_control;
  logic [W-1:0] ula_a;
  logic [W-1:0] ula_b;
  logic [W-1:0] ula_result;
  logic         ula_zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_err;
`ifdef ULA_ISSUE_PERF_EN
  logic [31:0]  perf_ops;
  logic [31:0]  perf_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ula_issue_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .op_a        (op_a),
    .op_b        (op_b),
    .ula_control (ula_control),
    .ula_a       (ula_a),
    .ula_b       (ula_b),
    .ula_result  (ula_result),
    .ula_zero    (ula_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_err     (out_err)
`ifdef ULA_ISSUE_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_err    (perf_err)
`endif
  );

  // Behavioural ULA responder; unknown control codes produce 0.
  always_comb begin
    case (ula_control)
      3'b000:  ula_result = ula_a & ula_b;
      3'b001:  ula_result = ula_a | ula_b;
      3'b010:  ula_result = ula_a + ula_b;
      3'b110:  ula_result = ula_a - ula_b;
      3'b111:  ula_result = ($signed(ula_a) < $signed(ula_b)) ? 32'd1 : 32'd0;
      3'b100:  ula_result = ~(ula_a | ula_b);
      default: ula_result = 32'd0;
    endcase
    ula_zero = (ula_result == 32'd0);
  end

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  // Present a request at a falling edge; returns one cycle later at the next falling edge.
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct = 6'd0; op_a = '0; op_b = '0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0 || ula_control !== 3'b000 || out_result !== 32'd0)
      begin bad++; $display("FAIL reset_outputs got v=%b ctrl=%b res=%h want 0/000/0", out_valid, ula_control, out_result); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    send(2'b10, 6'b100010, 32'd9, 32'd2);
    total++; if (ula_control !== 3'b110) begin bad++; $display("FAIL exec_ctrl got=%b want=110", ula_control); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || ula_control !== 3'b000 || ula_a !== 32'd0)
      begin bad++; $display("FAIL midexec_reset got v=%b rdy=%b ctrl=%b a=%h want 0/0/000/0", out_valid, in_ready, ula_control, ula_a); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dropped_txn got valid=%b want=0", out_valid); end
  endtask

  task automatic test_sub_zero();
    send(2'b10, 6'b100010, 32'd5, 32'd5);
    total++; if (out_valid !== 1'b0 || ula_control !== 3'b110 || ula_a !== 32'd5 || in_ready !== 1'b0)
      begin bad++; $display("FAIL sub_exec got v=%b ctrl=%b a=%h rdy=%b want 0/110/5/0", out_valid, ula_control, ula_a, in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1 || out_err !== 1'b0)
      begin bad++; $display("FAIL sub_result got v=%b r=%h z=%b e=%b want 1/0/1/0", out_valid, out_result, out_zero, out_err); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL sub_consume got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_slt();
    send(2'b10, 6'b101010, 32'd3, 32'd7);
    total++; if (ula_control !== 3'b111) begin bad++; $display("FAIL slt_ctrl got=%b want=111", ula_control); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_zero !== 1'b0 || out_err !== 1'b0)
      begin bad++; $display("FAIL slt_result got v=%b r=%h z=%b e=%b want 1/1/0/0", out_valid, out_result, out_zero, out_err); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    send(2'b11, 6'b100000, 32'd6, 32'd1);
    total++; if (ula_control !== 3'b011 || out_valid !== 1'b0)
      begin bad++; $display("FAIL ill_exec got ctrl=%b v=%b want 011/0", ula_control, out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b0 || out_err !== 1'b1)
      begin bad++; $display("FAIL ill_result got v=%b r=%h z=%b e=%b want 1/0/0/1", out_valid, out_result, out_zero, out_err); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_decode_table();
    vec_t v[8];
    v[0] = '{2'b00, 6'b000000, 32'd10,         32'd20,         3'b010, 32'd30,         1'b0, 1'b0};
    v[1] = '{2'b01, 6'b111111, 32'd9,          32'd4,          3'b110, 32'd5,          1'b0, 1'b0};
    v[2] = '{2'b10, 6'b100000, 32'd7,          32'd8,          3'b010, 32'd15,         1'b0, 1'b0};
    v[3] = '{2'b10, 6'b100100, 32'h000000F0,   32'h0000003C,   3'b000, 32'h00000030,   1'b0, 1'b0};
    v[4] = '{2'b10, 6'b100101, 32'h000000F0,   32'h0000000F,   3'b001, 32'h000000FF,   1'b0, 1'b0};
    v[5] = '{2'b10, 6'b100111, 32'd0,          32'd0,          3'b100, 32'hFFFFFFFF,   1'b0, 1'b0};
    v[6] = '{2'b10, 6'b101010, 32'hFFFFFFFF,   32'd1,          3'b111, 32'd1,          1'b0, 1'b0};
    v[7] = '{2'b10, 6'b000000, 32'd4,          32'd4,          3'b011, 32'd0,          1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      send(v[i].op, v[i].fn, v[i].a, v[i].b);
      total++; if (ula_control !== v[i].ctrl)
        begin bad++; $display("FAIL dec%0d_ctrl got=%b want=%b", i, ula_control, v[i].ctrl); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_result !== v[i].res || out_zero !== v[i].zero || out_err !== v[i].err)
        begin bad++; $display("FAIL dec%0d_result got v=%b r=%h z=%b e=%b want 1/%h/%b/%b",
                              i, out_valid, out_result, out_zero, out_err, v[i].res, v[i].zero, v[i].err); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    send(2'b00, 6'd0, 32'd10, 32'd20);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_result !== 32'd30 || in_ready !== 1'b0 || ula_a !== 32'd10)
        begin bad++; $display("FAIL stall%0d got v=%b r=%h rdy=%b a=%h want 1/1e/0/a", i, out_valid, out_result, in_ready, ula_a); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = 2'b10;
    funct     = 6'b100100;
    op_a      = 32'h000000F0;
    op_b      = 32'h0000003C;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || ula_control !== 3'b000 || ula_a !== 32'h000000F0)
      begin bad++; $display("FAIL b2b_exec got v=%b ctrl=%b a=%h want 0/000/f0", out_valid, ula_control, ula_a); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 32'h00000030 || out_zero !== 1'b0)
      begin bad++; $display("FAIL b2b_result got v=%b r=%h z=%b want 1/30/0", out_valid, out_result, out_zero); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef ULA_ISSUE_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (perf_ops !== 32'd0 || perf_err !== 32'd0)
      begin bad++; $display("FAIL perf_reset got ops=%0d err=%0d want 0/0", perf_ops, perf_err); end
    for (int i = 0; i < 10; i++) begin
      send((i == 3 || i == 7) ? 2'b11 : 2'b00, 6'd0, 32'(i), 32'd1);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    total++; if (perf_ops !== 32'd10 || perf_err !== 32'd2)
      begin bad++; $display("FAIL perf_count got ops=%0d err=%0d want 10/2", perf_ops, perf_err); end
    dut.r_perf_ops = 32'hFFFFFFFF;
    dut.r_perf_err = 32'hFFFFFFFF;
    send(2'b11, 6'd0, 32'd1, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (perf_ops !== 32'd0 || perf_err !== 32'd0)
      begin bad++; $display("FAIL perf_wrap got ops=%h err=%h want 0/0", perf_ops, perf_err); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sub_zero();
    test_slt();
    test_illegal();
    test_decode_table();
    test_back_to_back();
`ifdef ULA_ISSUE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
